// File: rtl/seg_scan.sv
// seg_scan -- four-digit multiplexed seven-segment scanner.
// Shows one hex digit at a time, advancing on each upstream TICK strobe, with
// DEAD all-off cycles between digits to stop ghosting on the display.
// Inputs are snapshotted once per frame, so a frame always shows one
// consistent value.
// Ports:
//   CLK    - sole clock, rising edge
//   RST_N  - asynchronous active-low reset
//   TICK   - one-cycle advance strobe from the clock divider
//   DATA   - four hex digits, DATA[4i+3:4i] is digit i
//   DP     - decimal point request per digit
//   BLANK  - per-digit blanking
//   DS_SEG - segments {g,f,e,d,c,b,a}, lit level SEG_ON
//   DS_DP  - decimal point segment, lit level SEG_ON
//   DS_EN  - digit enables, lit level EN_ON, bit i is digit i
//   FRAME  - one-cycle pulse marking a new input snapshot
module seg_scan #(
  parameter int unsigned DEAD   = 4,
  parameter logic        EN_ON  = 1'b1,
  parameter logic        SEG_ON = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        TICK,
  input  logic [15:0] DATA,
  input  logic [3:0]  DP,
  input  logic [3:0]  BLANK,
  output logic [6:0]  DS_SEG,
  output logic        DS_DP,
  output logic [3:0]  DS_EN,
  output logic        FRAME
);

  localparam logic [7:0] DEAD_LD = 8'(DEAD);
  localparam bit         NO_DEAD = (DEAD == 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEAD = 2'd1,
    ST_SHOW = 2'd2
  } state_t;

  state_t      r_state;
  logic [1:0]  r_idx;
  logic [7:0]  r_cnt;
  logic [15:0] r_data;
  logic [3:0]  r_dp;
  logic [3:0]  r_blank;
  logic        r_frame_pend;

  state_t      w_state_nxt;
  logic [1:0]  w_idx_nxt;
  logic [7:0]  w_cnt_nxt;
  logic        w_snap;

  logic [3:0]  w_en_nxt;
  logic [6:0]  w_seg_nxt;
  logic        w_dp_nxt;

  // Active-high gfedcba pattern for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      4'hF:    pat = 7'h71;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

  // State register, digit index, dead counter and per-frame input snapshot.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= ST_IDLE;
      r_idx        <= 2'd0;
      r_cnt        <= 8'd0;
      r_data       <= 16'h0000;
      r_dp         <= 4'h0;
      r_blank      <= 4'h0;
      r_frame_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_frame_pend <= w_snap;
      if (w_snap) begin
        r_data  <= DATA;
        r_dp    <= DP;
        r_blank <= BLANK;
      end
    end
  end

  // Next-state logic. TICK is only honoured in IDLE and SHOW, so strobes that
  // land in the dead gap (including its last cycle) are dropped, not queued.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_snap      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (TICK) begin
          w_snap    = 1'b1;
          w_idx_nxt = 2'd0;
          w_cnt_nxt = DEAD_LD;
          if (NO_DEAD) w_state_nxt = ST_SHOW;
          else         w_state_nxt = ST_DEAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DEAD: begin
        // Counter is loaded with DEAD on entry; leave after DEAD cycles.
        if (r_cnt <= 8'd1) begin
          w_state_nxt = ST_SHOW;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt   = r_cnt - 8'd1;
        end
      end
      ST_SHOW: begin
        if (TICK) begin
          w_idx_nxt = r_idx + 2'd1;
          w_snap    = (r_idx == 2'd3);
          w_cnt_nxt = DEAD_LD;
          if (NO_DEAD) w_state_nxt = ST_SHOW;
          else         w_state_nxt = ST_DEAD;
        end else begin
          w_state_nxt = ST_SHOW;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = 2'd0;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Display values for the current state; only SHOW of an unblanked digit
  // lights anything, and then only the one enable bit for r_idx.
  always_comb begin
    w_en_nxt  = {4{~EN_ON}};
    w_seg_nxt = {7{~SEG_ON}};
    w_dp_nxt  = ~SEG_ON;
    if ((r_state == ST_SHOW) && !r_blank[r_idx]) begin
      w_en_nxt[r_idx] = EN_ON;
      w_seg_nxt       = seg_decode(r_data[{r_idx, 2'b00} +: 4]) ^ {7{~SEG_ON}};
      if (r_dp[r_idx]) w_dp_nxt = SEG_ON;
      else             w_dp_nxt = ~SEG_ON;
    end else begin
      w_en_nxt = {4{~EN_ON}};
    end
  end

  // Output registers; reset drives the display dark immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DS_EN  <= {4{~EN_ON}};
      DS_SEG <= {7{~SEG_ON}};
      DS_DP  <= ~SEG_ON;
      FRAME  <= 1'b0;
    end else begin
      DS_EN  <= w_en_nxt;
      DS_SEG <= w_seg_nxt;
      DS_DP  <= w_dp_nxt;
      FRAME  <= r_frame_pend;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan: instance A uses default levels with DEAD=4,
// instance B uses DEAD=0 with inverted enable and segment levels.
module tb_seg_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_a = 1'b0;
  logic        tick_b = 1'b0;
  logic [15:0] data = 16'h0000;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  blank = 4'h0;

  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;
  logic [3:0]  en_a, en_b;
  logic        frame_a, frame_b;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seg_scan #(.DEAD(4), .EN_ON(1'b1), .SEG_ON(1'b1)) u_a (
    .CLK(clk), .RST_N(rst_n), .TICK(tick_a), .DATA(data), .DP(dp), .BLANK(blank),
    .DS_SEG(seg_a), .DS_DP(dp_a), .DS_EN(en_a), .FRAME(frame_a)
  );

  seg_scan #(.DEAD(0), .EN_ON(1'b0), .SEG_ON(1'b0)) u_b (
    .CLK(clk), .RST_N(rst_n), .TICK(tick_b), .DATA(data), .DP(dp), .BLANK(blank),
    .DS_SEG(seg_b), .DS_DP(dp_b), .DS_EN(en_b), .FRAME(frame_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 2 ns past the last one.
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // TICK high for exactly one sampling edge (edge t); returns at t+1 ns.
  task automatic pulse_a();
    tick_a = 1'b1;
    @(posedge clk);
    #1 tick_a = 1'b0;
  endtask

  task automatic pulse_b();
    tick_b = 1'b1;
    @(posedge clk);
    #1 tick_b = 1'b0;
  endtask

  // One digit advance on A: off with given FRAME at t+1, digit lit at t+5.
  task automatic step_a(input string tag, input logic exp_frame, input logic [3:0] exp_en,
                        input logic [6:0] exp_seg, input logic exp_dp);
    wait_cyc(14);
    pulse_a();
    wait_cyc(1);
    check({tag, "_frame"}, {31'd0, frame_a}, {31'd0, exp_frame});
    check({tag, "_dead_en"}, {28'd0, en_a}, 32'h0);
    wait_cyc(4);
    check({tag, "_en"}, {28'd0, en_a}, {28'd0, exp_en});
    check({tag, "_seg"}, {25'd0, seg_a}, {25'd0, exp_seg});
    check({tag, "_dp"}, {31'd0, dp_a}, {31'd0, exp_dp});
  endtask

  // At most one digit enabled at its lit level, every cycle, both instances.
  always @(negedge clk) begin
    check("onehot_a", {31'd0, ($countones(en_a) <= 1)}, 32'd1);
    check("onehot_b", {31'd0, ($countones(~en_b) <= 1)}, 32'd1);
  end

  initial begin
    // Reset state
    wait_cyc(3);
    check("rst_en_a", {28'd0, en_a}, 32'h0);
    check("rst_seg_a", {25'd0, seg_a}, 32'h0);
    check("rst_frame_a", {31'd0, frame_a}, 32'h0);
    check("rst_en_b", {28'd0, en_b}, 32'hF);
    check("rst_seg_b", {25'd0, seg_b}, 32'h7F);
    check("rst_dp_b", {31'd0, dp_b}, 32'h1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_cyc(3);
    check("idle_en_a", {28'd0, en_a}, 32'h0);
    check("idle_frame_a", {31'd0, frame_a}, 32'h0);

    // First frame, DATA=1234: FRAME at t+1, dark t+1..t+4, digit 0 at t+5
    data = 16'h1234;
    pulse_a();
    wait_cyc(1);
    check("f0_frame_t1", {31'd0, frame_a}, 32'h1);
    check("f0_en_t1", {28'd0, en_a}, 32'h0);
    wait_cyc(1);
    check("f0_frame_t2", {31'd0, frame_a}, 32'h0);
    wait_cyc(2);
    check("f0_en_t4", {28'd0, en_a}, 32'h0);
    wait_cyc(1);
    check("f0_en_t5", {28'd0, en_a}, 32'h1);
    check("f0_seg_t5", {25'd0, seg_a}, 32'h66);
    check("f0_dp_t5", {31'd0, dp_a}, 32'h0);

    // Mid-frame DATA change must not show until the wrap
    data = 16'hFFFF;
    step_a("d1", 1'b0, 4'b0010, 7'h4F, 1'b0);
    step_a("d2", 1'b0, 4'b0100, 7'h5B, 1'b0);
    step_a("d3", 1'b0, 4'b1000, 7'h06, 1'b0);
    step_a("wrap1", 1'b1, 4'b0001, 7'h71, 1'b0);

    // Blank digit 2, decimal point on digit 0 (taken at next wrap)
    data  = 16'h1234;
    blank = 4'b0100;
    dp    = 4'b0001;
    step_a("ff_d1", 1'b0, 4'b0010, 7'h71, 1'b0);
    step_a("ff_d2", 1'b0, 4'b0100, 7'h71, 1'b0);
    step_a("ff_d3", 1'b0, 4'b1000, 7'h71, 1'b0);
    step_a("bl_d0", 1'b1, 4'b0001, 7'h66, 1'b1);
    step_a("bl_d1", 1'b0, 4'b0010, 7'h4F, 1'b0);
    step_a("bl_d2", 1'b0, 4'b0000, 7'h00, 1'b0);

    // TICKs during DEAD and on the DEAD->SHOW edge are ignored
    wait_cyc(14);
    pulse_a();
    wait_cyc(1);
    pulse_a();
    wait_cyc(1);
    pulse_a();
    wait_cyc(1);
    check("ign_en_t5", {28'd0, en_a}, 32'h8);
    check("ign_seg_t5", {25'd0, seg_a}, 32'h06);
    wait_cyc(1);
    check("ign_en_t6", {28'd0, en_a}, 32'h8);

    // New frame without blanking, then reset while digit 2 is lit
    blank = 4'b0000;
    dp    = 4'b0000;
    step_a("r_d0", 1'b1, 4'b0001, 7'h66, 1'b0);
    step_a("r_d1", 1'b0, 4'b0010, 7'h4F, 1'b0);
    step_a("r_d2", 1'b0, 4'b0100, 7'h5B, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_rst_en", {28'd0, en_a}, 32'h0);
    check("async_rst_seg", {25'd0, seg_a}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_cyc(5);
    check("post_rst_en", {28'd0, en_a}, 32'h0);
    check("post_rst_frame", {31'd0, frame_a}, 32'h0);
    step_a("restart", 1'b1, 4'b0001, 7'h66, 1'b0);

    // Instance B: DEAD=0, active-low levels, DATA=5A0C, DP on digit 1
    data = 16'h5A0C;
    dp   = 4'b0010;
    check("b_idle_en", {28'd0, en_b}, 32'hF);
    pulse_b();
    wait_cyc(1);
    check("b_d0_frame", {31'd0, frame_b}, 32'h1);
    check("b_d0_en", {28'd0, en_b}, 32'hE);
    check("b_d0_seg", {25'd0, seg_b}, 32'h46);
    check("b_d0_dp", {31'd0, dp_b}, 32'h1);
    wait_cyc(1);
    check("b_d0_frame_t2", {31'd0, frame_b}, 32'h0);
    check("b_d0_en_t2", {28'd0, en_b}, 32'hE);
    wait_cyc(3);
    pulse_b();
    wait_cyc(1);
    check("b_d1_en", {28'd0, en_b}, 32'hD);
    check("b_d1_seg", {25'd0, seg_b}, 32'h40);
    check("b_d1_dp", {31'd0, dp_b}, 32'h0);
    wait_cyc(3);
    pulse_b();
    wait_cyc(1);
    check("b_d2_en", {28'd0, en_b}, 32'hB);
    check("b_d2_seg", {25'd0, seg_b}, 32'h08);
    wait_cyc(3);
    pulse_b();
    wait_cyc(1);
    check("b_d3_en", {28'd0, en_b}, 32'h7);
    check("b_d3_seg", {25'd0, seg_b}, 32'h12);
    check("b_d3_frame", {31'd0, frame_b}, 32'h0);
    wait_cyc(3);
    pulse_b();
    wait_cyc(1);
    check("b_wrap_frame", {31'd0, frame_b}, 32'h1);
    check("b_wrap_en", {28'd0, en_b}, 32'hE);
    check("b_wrap_seg", {25'd0, seg_b}, 32'h46);

    wait_cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 SHALL have parameter DEAD, default 4: all-off clock cycles inserted between digits (anti-ghosting), legal range 0..255.
REQ-002 SHALL have parameter EN_ON, default 1'b1: DS_EN level that lights a digit.
REQ-003 SHALL have parameter SEG_ON, default 1'b1: DS_SEG/DS_DP level that lights a segment.
REQ-004 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-005 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port TICK  input  1  one-CLK-wide advance strobe from the upstream clock divider.
REQ-007 SHALL have port DATA  input  16  four hex digits, DATA[4i+3:4i] is digit i.
REQ-008 SHALL have port DP  input  4  decimal point request, bit i is digit i.
REQ-009 SHALL have port BLANK  input  4  bit i set keeps digit i dark.
REQ-010 SHALL have port DS_SEG  output  7  segments {g,f,e,d,c,b,a}.
REQ-011 SHALL have port DS_DP  output  1  decimal point segment.
REQ-012 SHALL have port DS_EN  output  4  digit enables, bit i is digit i (board DS_EN1 = bit 0).
REQ-013 SHALL have port FRAME  output  1  one-cycle pulse when a new input snapshot is taken.

Function
REQ-014 SHALL implement states IDLE, DEAD, SHOW, plus a 2-bit digit index IDX, an 8-bit dead counter, and snapshot registers for DATA, DP, BLANK.
REQ-015 All outputs SHALL be registered; "off" means DS_EN = ~EN_ON on all 4 bits, DS_SEG = {7{~SEG_ON}}, DS_DP = ~SEG_ON.
REQ-016 IDLE: outputs off; on TICK, SHALL snapshot DATA/DP/BLANK, set IDX=0, pulse FRAME next cycle, enter DEAD.
REQ-017 SHOW: enable bit IDX at EN_ON (others off) unless snapshot BLANK[IDX]=1, in which case all off; DS_SEG = decode(snapshot nibble IDX); DS_DP = SEG_ON when snapshot DP[IDX]=1, else off.
REQ-018 SHOW with TICK: next cycle outputs off, IDX increments mod 4, state DEAD, counter loaded with DEAD.
REQ-019 When IDX wraps 3->0 SHALL take a new snapshot and pulse FRAME for exactly one cycle, simultaneous with the first DEAD cycle; inputs SHALL NOT affect outputs mid-frame.
REQ-020 DEAD: outputs off for exactly DEAD cycles, then SHOW for IDX; with DEAD=0, SHOW for the new IDX appears in the cycle directly after the TICK, with no off cycle.
REQ-021 TICK asserted while in DEAD or on the DEAD->SHOW transition cycle SHALL be ignored (not queued).
REQ-022 Latency: TICK at edge t in IDLE -> digit 0 lit at edge t+1+DEAD.
REQ-023 Decode SHALL be the standard hex set: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71 (active-high gfedcba, inverted when SEG_ON=0).
REQ-024 No more than one DS_EN bit SHALL be at EN_ON in any cycle.

Reset
REQ-025 RST_N low SHALL immediately and asynchronously force state IDLE, IDX=0, counter=0, snapshots=0, FRAME=0, all display outputs off.
REQ-026 Reset asserted mid-scan SHALL discard the frame; after release the block SHALL wait in IDLE for the next TICK.
REQ-027 Reset release SHALL be synchronous in effect: no state change on the release edge without TICK.

Verification
REQ-028 Reset then TICK with DATA=16'h1234, DP=0, BLANK=0, DEAD=4 -> FRAME at t+1, outputs off t+1..t+4, at t+5 DS_EN=4'b0001, DS_SEG=7'h66.
REQ-029 Four further TICKs spaced 20 cycles -> digits 1,2,3 show 7'h4F, 7'h5B, 7'h06; 4th TICK wraps to digit 0 with FRAME pulse; DATA changed to 16'hFFFF mid-frame has no effect until wrap.
REQ-030 BLANK=4'b0100, DP=4'b0001 -> digit 2 slot all off, digit 0 shows DS_DP=SEG_ON, others DS_DP off.
REQ-031 DEAD=0: TICK at t in SHOW -> next digit lit at t+1; TICK during DEAD (DEAD=4) -> ignored, timing unchanged.
REQ-032 RST_N low for 1 cycle while digit 2 shown -> outputs off in same cycle, IDLE held until next TICK, which restarts at digit 0 with FRAME.
REQ-033 Parameters EN_ON=0, SEG_ON=0 -> all levels inverted; checker asserts REQ-024 one-hot every cycle across all scenarios.
